// File: rtl/branch_predictor.sv
// Purpose: direct-mapped BTB with 2-bit saturating counters; predicts taken/target for the fetch PC.
// Latency: lookup is combinational (0 cycles); training is visible to lookup one cycle after the update edge.
// Backpressure: none; accepts one resolved branch per cycle, and updates with rdy low are dropped.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              pred_jmp_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_is_jmp_i,
    input  logic              ex_jmp_res_i,
    input  logic [ADDR_W-1:0] ex_dest_i,
    input  logic              ex_b_flag_i,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;
    localparam int ENTRIES = 1 << INDEX_BITS;

    // Counter encoding: MSB set means predict taken.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Table state, one entry per index.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Statistics.
    logic [31:0] branch_cnt_q;
    logic [31:0] miss_cnt_q;

    // Lookup side decode.
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;

    // Training side decode.
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      ex_tag;
    logic                  ex_hit;
    logic                  upd_en;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_inc;
    logic [1:0]            ctr_dec;

    // Instructions are word aligned, so the low two PC bits never select anything.
    logic ex_pc_unused;
    assign ex_pc_unused = ^ex_pc_i[1:0];

    assign if_idx = if_pc_i[INDEX_BITS+1:2];
    assign if_tag = if_pc_i[ADDR_W-1:INDEX_BITS+2];
    assign ex_idx = ex_pc_i[INDEX_BITS+1:2];
    assign ex_tag = ex_pc_i[ADDR_W-1:INDEX_BITS+2];

    assign upd_en = rdy && ex_is_jmp_i;

    // Combinational lookup from registered state, so a same-cycle update is never seen (read-before-write).
    always_comb begin
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_jmp_o    = if_hit && ctr_q[if_idx][1];
        pred_target_o = pred_jmp_o ? target_q[if_idx] : (if_pc_i + ADDR_W'(4));
    end

    // Saturating next-counter values for the entry addressed by execute.
    always_comb begin
        ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ctr_cur = ctr_q[ex_idx];
        ctr_inc = (ctr_cur == CTR_STRONG_T)  ? CTR_STRONG_T  : ctr_cur + 2'd1;
        ctr_dec = (ctr_cur == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr_cur - 2'd1;
    end

    // Table training: strengthen/weaken on hit, allocate only on a taken miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (upd_en) begin
            if (ex_hit) begin
                if (ex_jmp_res_i) begin
                    ctr_q[ex_idx]    <= ctr_inc;
                    target_q[ex_idx] <= ex_dest_i;
                end else begin
                    ctr_q[ex_idx] <= ctr_dec;
                end
            end else if (ex_jmp_res_i) begin
                // Evicts whatever aliased into this slot.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_dest_i;
                ctr_q[ex_idx]    <= CTR_WEAK_T;
            end
        end
    end

    // Saturating statistics; a redirect without a resolved branch (JALR) is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (upd_en) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (ex_b_flag_i && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
